alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Pipeline register between decode/register-read and the 32-bit ALU; drives the ALU's op1, op2 and 3-bit sel directly.
- Holds one instruction with a valid/ready handshake on each side.
- Selects a sign-extended immediate for op2 when requested.
- Applies operand forwarding from the two later stages, so the ALU always sees current register values.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register index width.
- IMM_W, 16, immediate width; sign-extended to DATA_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_rs_val  in  DATA_W  register-file value of rs.
- in_rt_val  in  DATA_W  register-file value of rt.
- in_rs_idx  in  REG_AW  rs index.
- in_rt_idx  in  REG_AW  rt index.
- in_imm  in  IMM_W  immediate field.
- in_use_imm  in  1  op2 = sign-extended immediate.
- in_sel  in  3  ALU op code: 000 and, 001 or, 010 add, 011 sub, 100 slt, 101 const 1.
- in_rd_idx  in  REG_AW  destination index.
- in_wr_en  in  1  instruction writes rd.
- flush  in  1  kill held and incoming instruction.
- fwd1_valid  in  1  EX/MEM result is writing a register.
- fwd1_idx  in  REG_AW  EX/MEM destination index.
- fwd1_data  in  DATA_W  EX/MEM result value.
- fwd2_valid  in  1  MEM/WB result is writing a register.
- fwd2_idx  in  REG_AW  MEM/WB destination index.
- fwd2_data  in  DATA_W  MEM/WB result value.
- out_valid  out  1  held instruction valid.
- out_ready  in  1  downstream consumes the ALU result this cycle.
- op1  out  DATA_W  ALU operand 1.
- op2  out  DATA_W  ALU operand 2.
- sel  out  3  ALU op code.
- out_rd_idx  out  REG_AW  held destination index.
- out_wr_en  out  1  held wr_en, gated by out_valid.

Behaviour:
- Reset (async, immediate):
  - out_valid=0.
  - All held fields 0, except held sel=3'b111, which makes the ALU output 0.
  - op1=op2=0 and out_wr_en=0.
- Ready logic: in_ready = !flush && (!out_valid || out_ready). This is combinational, with no bubble when draining and refilling in the same cycle.
- Capture on the clk edge when in_valid && in_ready:
  - Latch rs_val, rt_val, rs_idx, rt_idx, imm, use_imm, sel, rd_idx, wr_en.
  - Set out_valid=1.
- Drain: out_valid && out_ready with no capture in the same cycle → out_valid=0 next cycle. Held fields are retained, not cleared.
- Stall: out_valid && !out_ready → every held field is frozen.
- Flush (synchronous): out_valid=0 next edge; incoming data is dropped (in_ready=0). Flush takes priority over capture and drain.
- op1 (combinational from held state):
  - fwd1_data if fwd1_valid && fwd1_idx==rs_idx && rs_idx!=0.
  - else fwd2_data if fwd2_valid && fwd2_idx==rs_idx && rs_idx!=0.
  - else held rs_val.
- op2:
  - use_imm=1 → {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm}; no forwarding applied.
  - use_imm=0 → same priority forwarding on rt_idx, else held rt_val.
- Forwarding rules:
  - fwd1 (newer) beats fwd2.
  - Index 0 is never forwarded; register 0 always reads held value.
  - Forwarding is re-evaluated every cycle while stalled, so the operands track late-arriving results.
- sel: driven from the held value. When out_valid=0, sel=3'b111, op1=op2=0 and out_wr_en=0; the ALU produces 0 and ZF=1.
- Latency: 1 cycle from accept to operands on the ALU.
- Back-to-back: throughput is one instruction per cycle while out_ready=1.
- Reset mid-stall discards the held instruction; out_valid=0 with no glitch to 1.

Optional Feature:
- Macro ALU_ISSUE_PERF_EN.
- When defined, adds outputs:
  - perf_issued (32): increments when out_valid && out_ready && !flush.
  - perf_stall (32): increments when out_valid && !out_ready.
  - perf_clr (in, 1): synchronously zeroes both counters.
- Counters wrap at 2^32 and reset to 0 on rst.
- Undefined: no ports or logic added; behaviour otherwise identical.

Test Plan:
- Reset, then hold out_ready=1 and send in_valid with rs_val=5, rt_val=3, sel=010 → next cycle out_valid=1, op1=5, op2=3, sel=010; ALU gives 8.
- Stall: load an instruction, hold out_ready=0 for 3 cycles while offering a new one → in_ready=0, all outputs frozen. Raise out_ready → new instruction appears the following cycle with no gap.
- Forwarding on op1, held rs_idx=4 and rs_val=0:
  - fwd1 (idx 4, data 0x11) and fwd2 (idx 4, data 0x22) both active → op1=0x11.
  - drop fwd1 → op1=0x22.
  - rs_idx=0 with both forwards hitting idx 0 → op1=held value.
- Immediate: use_imm=1, imm=0xFFFE, fwd1 active on rt_idx → op2=0xFFFFFFFE; forwarding ignored.
- Flush asserted together with in_valid while holding a valid entry → next cycle out_valid=0, sel=111, out_wr_en=0; the incoming instruction never appears.
- With ALU_ISSUE_PERF_EN: 4 issues plus 2 stall cycles → perf_issued=4, perf_stall=2; perf_clr → both 0 next cycle.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Single-entry pipeline register sitting between decode/register-read and a
// 32-bit ALU. Holds one instruction behind a valid/ready handshake on each
// side, drives the ALU operands and op code directly, selects a sign-extended
// immediate for op2 on request, and applies operand forwarding from the two
// later pipeline stages (EX/MEM = fwd1, MEM/WB = fwd2).
//
// Optional feature (macro ALU_ISSUE_PERF_EN): adds perf_issued / perf_stall
// event counters and a synchronous perf_clr input. With the macro undefined
// the block has no extra ports or logic.
//
// Ports:
//   clk, rst              rising-edge clock, async active-high reset
//   in_valid/in_ready     upstream handshake
//   in_rs_val, in_rt_val  register-file operand values
//   in_rs_idx, in_rt_idx  source register indices
//   in_imm, in_use_imm    immediate field and op2-immediate select
//   in_sel                ALU op code
//   in_rd_idx, in_wr_en   destination index and write enable
//   flush                 kill held and incoming instruction
//   fwd1_*                EX/MEM forwarding source (higher priority)
//   fwd2_*                MEM/WB forwarding source
//   out_valid/out_ready   downstream handshake
//   op1, op2, sel         ALU operands and op code
//   out_rd_idx, out_wr_en held destination index, gated write enable
//   perf_clr, perf_issued, perf_stall   (ALU_ISSUE_PERF_EN only)
// ---------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_rs_val,
    input  logic [DATA_W-1:0] in_rt_val,
    input  logic [REG_AW-1:0] in_rs_idx,
    input  logic [REG_AW-1:0] in_rt_idx,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              in_use_imm,
    input  logic [2:0]        in_sel,
    input  logic [REG_AW-1:0] in_rd_idx,
    input  logic              in_wr_en,
    input  logic              flush,
    input  logic              fwd1_valid,
    input  logic [REG_AW-1:0] fwd1_idx,
    input  logic [DATA_W-1:0] fwd1_data,
    input  logic              fwd2_valid,
    input  logic [REG_AW-1:0] fwd2_idx,
    input  logic [DATA_W-1:0] fwd2_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    output logic [2:0]        sel,
    output logic [REG_AW-1:0] out_rd_idx,
    output logic              out_wr_en
`ifdef ALU_ISSUE_PERF_EN
    ,
    input  logic              perf_clr,
    output logic [31:0]       perf_issued,
    output logic [31:0]       perf_stall
`endif
);

    // op code that makes the ALU output zero; parked here whenever idle
    localparam logic [2:0] SEL_IDLE = 3'b111;

    typedef struct packed {
        logic [DATA_W-1:0] rs_val;
        logic [DATA_W-1:0] rt_val;
        logic [REG_AW-1:0] rs_idx;
        logic [REG_AW-1:0] rt_idx;
        logic [IMM_W-1:0]  imm;
        logic              use_imm;
        logic [2:0]        sel;
        logic [REG_AW-1:0] rd_idx;
        logic              wr_en;
    } held_t;

    localparam held_t HELD_RST = '{
        rs_val:  '0,
        rt_val:  '0,
        rs_idx:  '0,
        rt_idx:  '0,
        imm:     '0,
        use_imm: 1'b0,
        sel:     SEL_IDLE,
        rd_idx:  '0,
        wr_en:   1'b0
    };

    held_t held;
    held_t incoming;
    logic  capture;

    // -----------------------------------------------------------------------
    // Handshake. in_ready lets a drain and a refill share one edge, so a
    // continuously ready consumer sees one instruction per cycle.
    // -----------------------------------------------------------------------
    assign in_ready = !flush && (!out_valid || out_ready);
    assign capture  = in_valid && in_ready;

    always_comb begin
        incoming         = HELD_RST;
        incoming.rs_val  = in_rs_val;
        incoming.rt_val  = in_rt_val;
        incoming.rs_idx  = in_rs_idx;
        incoming.rt_idx  = in_rt_idx;
        incoming.imm     = in_imm;
        incoming.use_imm = in_use_imm;
        incoming.sel     = in_sel;
        incoming.rd_idx  = in_rd_idx;
        incoming.wr_en   = in_wr_en;
    end

    // Held fields only ever change on capture: draining or flushing clears
    // out_valid but leaves the data in place (it is masked on the outputs).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            held      <= HELD_RST;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            held      <= incoming;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Forwarding. Evaluated every cycle from the held indices, so a stalled
    // instruction keeps picking up results that land while it waits.
    // Register 0 is hard-wired and never forwarded.
    // -----------------------------------------------------------------------
    logic              rs_hit1, rs_hit2, rt_hit1, rt_hit2;
    logic [DATA_W-1:0] rs_cur, rt_cur, imm_ext;

    assign rs_hit1 = fwd1_valid && (fwd1_idx == held.rs_idx) && (held.rs_idx != '0);
    assign rs_hit2 = fwd2_valid && (fwd2_idx == held.rs_idx) && (held.rs_idx != '0);
    assign rt_hit1 = fwd1_valid && (fwd1_idx == held.rt_idx) && (held.rt_idx != '0);
    assign rt_hit2 = fwd2_valid && (fwd2_idx == held.rt_idx) && (held.rt_idx != '0);

    assign imm_ext = {{(DATA_W-IMM_W){held.imm[IMM_W-1]}}, held.imm};

    always_comb begin
        rs_cur = held.rs_val;
        if (rs_hit1)      rs_cur = fwd1_data;
        else if (rs_hit2) rs_cur = fwd2_data;

        rt_cur = held.rt_val;
        if (rt_hit1)      rt_cur = fwd1_data;
        else if (rt_hit2) rt_cur = fwd2_data;
    end

    // Idle outputs are forced so the ALU yields 0 with nothing issued.
    always_comb begin
        op1       = '0;
        op2       = '0;
        sel       = SEL_IDLE;
        out_wr_en = 1'b0;
        if (out_valid) begin
            op1       = rs_cur;
            op2       = held.use_imm ? imm_ext : rt_cur;
            sel       = held.sel;
            out_wr_en = held.wr_en;
        end
    end

    assign out_rd_idx = held.rd_idx;

`ifdef ALU_ISSUE_PERF_EN
    // -----------------------------------------------------------------------
    // Event counters, free-running and wrapping at 2^32.
    // -----------------------------------------------------------------------
    logic issue_evt, stall_evt;

    assign issue_evt = out_valid && out_ready && !flush;
    assign stall_evt = out_valid && !out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else if (perf_clr) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (issue_evt) perf_issued <= perf_issued + 32'd1;
            if (stall_evt) perf_stall  <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_rs_val, in_rt_val;
    logic [4:0]  in_rs_idx, in_rt_idx, in_rd_idx;
    logic [15:0] in_imm;
    logic        in_use_imm, in_wr_en;
    logic [2:0]  in_sel;
    logic        flush;
    logic        fwd1_valid, fwd2_valid;
    logic [4:0]  fwd1_idx, fwd2_idx;
    logic [31:0] fwd1_data, fwd2_data;
    logic        out_valid, out_ready;
    logic [31:0] op1, op2;
    logic [2:0]  sel;
    logic [4:0]  out_rd_idx;
    logic        out_wr_en;
`ifdef ALU_ISSUE_PERF_EN
    logic        perf_clr;
    logic [31:0] perf_issued, perf_stall;
`endif

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_sel(in_sel),
        .in_rd_idx(in_rd_idx), .in_wr_en(in_wr_en),
        .flush(flush),
        .fwd1_valid(fwd1_valid), .fwd1_idx(fwd1_idx), .fwd1_data(fwd1_data),
        .fwd2_valid(fwd2_valid), .fwd2_idx(fwd2_idx), .fwd2_data(fwd2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .op1(op1), .op2(op2), .sel(sel),
        .out_rd_idx(out_rd_idx), .out_wr_en(out_wr_en)
`ifdef ALU_ISSUE_PERF_EN
        , .perf_clr(perf_clr), .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] rs_val, rt_val;
        logic [4:0]  rs_idx, rt_idx, rd_idx;
        logic [15:0] imm;
        logic        use_imm;
        logic [2:0]  op;
        logic        f1v; logic [4:0] f1i; logic [31:0] f1d;
        logic        f2v; logic [4:0] f2i; logic [31:0] f2d;
        logic [31:0] e_op1, e_op2;
    } vec_t;

    vec_t vecs[7];

    // ---------------- reference model ----------------
    typedef struct {
        logic        v;
        logic [31:0] rs_val, rt_val;
        logic [4:0]  rs_idx, rt_idx, rd_idx;
        logic [15:0] imm;
        logic        use_imm, wr_en;
        logic [2:0]  op;
    } mdl_t;

    mdl_t m;

    // Current architectural value of a register as seen by the ALU:
    // newest in-flight result wins, register 0 is never overridden.
    function automatic logic [31:0] reg_now(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return rf;
        if (fwd1_valid && fwd1_idx == idx) return fwd1_data;
        if (fwd2_valid && fwd2_idx == idx) return fwd2_data;
        return rf;
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return v[15] ? (32'hFFFF_0000 + 32'(v)) : 32'(v);
    endfunction

    task automatic idle_inputs();
        in_valid = 0; in_rs_val = 0; in_rt_val = 0; in_rs_idx = 0; in_rt_idx = 0;
        in_rd_idx = 0; in_imm = 0; in_use_imm = 0; in_wr_en = 0; in_sel = 0;
        flush = 0; fwd1_valid = 0; fwd1_idx = 0; fwd1_data = 0;
        fwd2_valid = 0; fwd2_idx = 0; fwd2_data = 0; out_ready = 1;
    endtask

    task automatic put(input logic [31:0] rsv, input logic [4:0] rsi,
                       input logic [31:0] rtv, input logic [4:0] rti, input logic [2:0] op);
        in_valid = 1; in_rs_val = rsv; in_rs_idx = rsi; in_rt_val = rtv; in_rt_idx = rti;
        in_sel = op; in_use_imm = 0; in_imm = 0; in_rd_idx = 5'd3; in_wr_en = 1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1; #1; @(posedge clk); #1; rst = 0;
    endtask

    initial begin
        vecs[0] = '{32'd5, 32'd3, 5'd1, 5'd2, 5'd7, 16'h0, 1'b0, 3'b010,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'd5, 32'd3};
        vecs[1] = '{32'h0, 32'h1, 5'd4, 5'd2, 5'd8, 16'h0, 1'b0, 3'b000,
                    1'b1, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22, 32'h11, 32'h1};
        vecs[2] = '{32'h0, 32'h1, 5'd4, 5'd2, 5'd9, 16'h0, 1'b0, 3'b001,
                    1'b0, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22, 32'h22, 32'h1};
        vecs[3] = '{32'h77, 32'h66, 5'd0, 5'd0, 5'd10, 16'h0, 1'b0, 3'b011,
                    1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22, 32'h77, 32'h66};
        vecs[4] = '{32'h1, 32'h9, 5'd5, 5'd6, 5'd11, 16'hFFFE, 1'b1, 3'b010,
                    1'b1, 5'd6, 32'h33, 1'b0, 5'd0, 32'h0, 32'h1, 32'hFFFF_FFFE};
        vecs[5] = '{32'h2, 32'h9, 5'd5, 5'd6, 5'd12, 16'h7FFF, 1'b1, 3'b100,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h2, 32'h0000_7FFF};
        vecs[6] = '{32'h2, 32'h9, 5'd5, 5'd7, 5'd13, 16'h0, 1'b0, 3'b101,
                    1'b1, 5'd5, 32'hAB, 1'b1, 5'd7, 32'hCD, 32'hAB, 32'hCD};

        idle_inputs();
`ifdef ALU_ISSUE_PERF_EN
        perf_clr = 0;
`endif
        rst = 1; #2;
        // reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sel", 32'(sel), 32'd7);
        chk("rst_op1", op1, 32'd0);
        chk("rst_op2", op2, 32'd0);
        chk("rst_wr_en", 32'(out_wr_en), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1; rst = 0;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 7; i++) begin
            idle_inputs();
            in_valid = 1; in_rs_val = vecs[i].rs_val; in_rt_val = vecs[i].rt_val;
            in_rs_idx = vecs[i].rs_idx; in_rt_idx = vecs[i].rt_idx; in_rd_idx = vecs[i].rd_idx;
            in_imm = vecs[i].imm; in_use_imm = vecs[i].use_imm; in_sel = vecs[i].op; in_wr_en = 1;
            tick();
            in_valid = 0; out_ready = 0;
            fwd1_valid = vecs[i].f1v; fwd1_idx = vecs[i].f1i; fwd1_data = vecs[i].f1d;
            fwd2_valid = vecs[i].f2v; fwd2_idx = vecs[i].f2i; fwd2_data = vecs[i].f2d;
            #1;
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_op1", i), op1, vecs[i].e_op1);
            chk($sformatf("vec%0d_op2", i), op2, vecs[i].e_op2);
            chk($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].op));
            chk($sformatf("vec%0d_rd", i), 32'(out_rd_idx), 32'(vecs[i].rd_idx));
            chk($sformatf("vec%0d_wr_en", i), 32'(out_wr_en), 32'd1);
        end

        // ---------------- stall with late forward, then no-gap refill ----------------
        idle_inputs();
        put(32'hA1, 5'd9, 32'h1, 5'd1, 3'b010);
        tick();
        put(32'hB2, 5'd10, 32'h2, 5'd1, 3'b011);
        out_ready = 0;
        for (int c = 0; c < 3; c++) begin
            fwd1_valid = (c == 1); fwd1_idx = 5'd9; fwd1_data = 32'h99;
            #1;
            chk($sformatf("stall%0d_in_ready", c), 32'(in_ready), 32'd0);
            chk($sformatf("stall%0d_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_op1", c), op1, (c == 1) ? 32'h99 : 32'hA1);
            chk($sformatf("stall%0d_sel", c), 32'(sel), 32'd2);
            tick();
        end
        fwd1_valid = 0; out_ready = 1; #1;
        chk("refill_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 0;
        chk("refill_valid", 32'(out_valid), 32'd1);
        chk("refill_op1", op1, 32'hB2);
        chk("refill_sel", 32'(sel), 32'd3);
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_sel", 32'(sel), 32'd7);
        chk("drain_op1", op1, 32'd0);

        // ---------------- flush with incoming instruction ----------------
        put(32'hC3, 5'd11, 32'h3, 5'd1, 3'b000);
        tick();
        put(32'hD4, 5'd12, 32'h4, 5'd1, 3'b001);
        flush = 1; #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 0; in_valid = 0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_sel", 32'(sel), 32'd7);
        chk("flush_op1", op1, 32'd0);
        chk("flush_wr_en", 32'(out_wr_en), 32'd0);
        tick();
        chk("flush_dropped", 32'(out_valid), 32'd0);

        // ---------------- async reset during stall ----------------
        put(32'hE5, 5'd13, 32'h5, 5'd1, 3'b010);
        tick();
        in_valid = 0; out_ready = 0;
        tick();
        chk("prerst_valid", 32'(out_valid), 32'd1);
        rst = 1; #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_sel", 32'(sel), 32'd7);
        tick();
        rst = 0; out_ready = 1; #1;
        chk("postrst_valid", 32'(out_valid), 32'd0);

`ifdef ALU_ISSUE_PERF_EN
        // ---------------- perf counters ----------------
        idle_inputs();
        perf_clr = 1; tick(); perf_clr = 0;
        for (int k = 0; k < 4; k++) begin
            put(32'(k), 5'd1, 32'h0, 5'd2, 3'b010);
            tick();
        end
        in_valid = 0; out_ready = 0;
        tick(); tick();
        out_ready = 1;
        tick(); tick();
        chk("perf_issued", perf_issued, 32'd4);
        chk("perf_stall", perf_stall, 32'd2);
        perf_clr = 1; tick(); perf_clr = 0;
        chk("perf_issued_clr", perf_issued, 32'd0);
        chk("perf_stall_clr", perf_stall, 32'd0);
`endif

        // ---------------- randomized run against the model ----------------
        idle_inputs();
        do_reset();
        m = '{v: 1'b0, op: 3'b111, default: '0};
        for (int n = 0; n < 400; n++) begin
            logic exp_ready;
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 9) < 7);
            flush      = ($urandom_range(0, 9) == 0);
            in_rs_val  = $urandom; in_rt_val = $urandom;
            in_rs_idx  = 5'($urandom_range(0, 3)); in_rt_idx = 5'($urandom_range(0, 3));
            in_rd_idx  = 5'($urandom_range(0, 31));
            in_imm     = 16'($urandom); in_use_imm = $urandom_range(0, 1) == 1;
            in_sel     = 3'($urandom_range(0, 5)); in_wr_en = $urandom_range(0, 1) == 1;
            fwd1_valid = $urandom_range(0, 1) == 1; fwd1_idx = 5'($urandom_range(0, 3));
            fwd1_data  = $urandom;
            fwd2_valid = $urandom_range(0, 1) == 1; fwd2_idx = 5'($urandom_range(0, 3));
            fwd2_data  = $urandom;
            #1;
            exp_ready = !flush && (!m.v || out_ready);
            chk("rnd_in_ready", 32'(in_ready), 32'(exp_ready));
            chk("rnd_valid", 32'(out_valid), 32'(m.v));
            chk("rnd_op1", op1, m.v ? reg_now(m.rs_idx, m.rs_val) : 32'd0);
            chk("rnd_op2", op2, !m.v ? 32'd0 :
                                m.use_imm ? sext16(m.imm) : reg_now(m.rt_idx, m.rt_val));
            chk("rnd_sel", 32'(sel), m.v ? 32'(m.op) : 32'd7);
            chk("rnd_wr_en", 32'(out_wr_en), 32'(m.v && m.wr_en));
            if (m.v) chk("rnd_rd", 32'(out_rd_idx), 32'(m.rd_idx));
            @(posedge clk);
            if (flush) m.v = 0;
            else if (in_valid && exp_ready)
                m = '{v: 1'b1, rs_val: in_rs_val, rt_val: in_rt_val, rs_idx: in_rs_idx,
                      rt_idx: in_rt_idx, rd_idx: in_rd_idx, imm: in_imm,
                      use_imm: in_use_imm, wr_en: in_wr_en, op: in_sel};
            else if (out_ready) m.v = 0;
            #1;
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
